// File: rtl/uart_tx_engine_if.sv
// Byte-in / serial-out handshake between the UART register block and the
// transmit engine; the register logic is the master, the engine the slave.
interface uart_tx_engine_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic       tx_busy;
  logic       uart_tx;

  modport master (
    output tx_data,
    output tx_en,
    input  tx_status,
    input  tx_busy,
    input  uart_tx
  );

  modport slave (
    input  tx_data,
    input  tx_en,
    output tx_status,
    output tx_busy,
    output uart_tx
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2
// stop bits, with a one-deep holding register for the next byte.
module uart_tx_engine #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input logic          sysclk,
  input logic          reset,
  uart_tx_engine_if.slave bus
);

  localparam int unsigned DIV       = CLK_FREQ / BAUD;
  localparam int unsigned CW        = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic HAS_PAR          = (PARITY != 0);
  localparam logic ODD              = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          par, par_d;
  logic [7:0]    hold, hold_d;
  logic          hold_full, hold_full_d;
  logic          line_q, line_d;
  logic          status_q, busy_q;
  logic          bit_end, frame_end;

  // Parity is captured at load time because the shift register is consumed.
  function automatic logic par_of(input logic [7:0] b);
    return (^b) ^ ODD;
  endfunction

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      par       <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      line_q    <= 1'b1;
      status_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shift     <= shift_d;
      par       <= par_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      line_q    <= line_d;
      status_q  <= ~hold_full_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    shift_d     = shift;
    par_d       = par;
    hold_d      = hold;
    hold_full_d = hold_full;
    line_d      = 1'b1;
    bit_end     = (cnt == CNT_LAST);
    frame_end   = 1'b0;

    if (state != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt + CW'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (bus.tx_en) begin
          state_d = S_START;
          shift_d = bus.tx_data;
          par_d   = par_of(bus.tx_data);
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
            idx_d   = '0;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx == STOP_LAST) frame_end = 1'b1;
          else                  idx_d     = idx + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame end chains straight into the next start; otherwise a strobe fills holding.
    if (frame_end) begin
      idx_d = '0;
      if (hold_full) begin
        state_d     = S_START;
        shift_d     = hold;
        par_d       = par_of(hold);
        hold_full_d = 1'b0;
      end else if (bus.tx_en) begin
        state_d = S_START;
        shift_d = bus.tx_data;
        par_d   = par_of(bus.tx_data);
      end else begin
        state_d = S_IDLE;
      end
    end else if ((state != S_IDLE) && bus.tx_en && !hold_full) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  assign bus.uart_tx   = line_q;
  assign bus.tx_status = status_q;
  assign bus.tx_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: 8N1, 8E2 and 8O1 instances share one stimulus and
// are compared every cycle with a frame-timing reference model.
module tb_uart_tx_engine;

  localparam int unsigned CLK_FREQ = 1600;
  localparam int unsigned BAUD     = 100;
  localparam int          DIV      = 16;
  localparam int          NCFG     = 3;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       en_drv = 1'b0;
  logic [7:0] data_drv = 8'h00;

  always #5 sysclk = ~sysclk;

  uart_tx_engine_if if0 ();
  uart_tx_engine_if if1 ();
  uart_tx_engine_if if2 ();

  assign if0.tx_en = en_drv;  assign if0.tx_data = data_drv;
  assign if1.tx_en = en_drv;  assign if1.tx_data = data_drv;
  assign if2.tx_en = en_drv;  assign if2.tx_data = data_drv;

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1))
    dut0 (.sysclk(sysclk), .reset(reset), .bus(if0));
  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(1), .STOP_BITS(2))
    dut1 (.sysclk(sysclk), .reset(reset), .bus(if1));
  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(1))
    dut2 (.sysclk(sysclk), .reset(reset), .bus(if2));

  logic [2:0] obs0, obs1, obs2;
  assign obs0 = {if0.uart_tx, if0.tx_busy, if0.tx_status};
  assign obs1 = {if1.uart_tx, if1.tx_busy, if1.tx_status};
  assign obs2 = {if2.uart_tx, if2.tx_busy, if2.tx_status};

  function automatic logic [2:0] obs(input int c);
    case (c)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: tx/busy/status got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of DIV-cycle bit slots starting at edge k.
  function automatic int par_cfg(input int c);  return (c == 1) ? 1 : ((c == 2) ? 2 : 0); endfunction
  function automatic int stop_cfg(input int c); return (c == 1) ? 2 : 1; endfunction
  function automatic int flen(input int c);
    return DIV * (9 + ((par_cfg(c) != 0) ? 1 : 0) + stop_cfg(c));
  endfunction

  function automatic logic fbit(input int c, input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && par_cfg(c) != 0) return (par_cfg(c) == 1) ? (^b) : ~(^b);
    return 1'b1;
  endfunction

  logic       m_act  [NCFG];
  int         m_k    [NCFG];
  logic [7:0] m_cur  [NCFG];
  logic [7:0] m_hold [NCFG];
  logic       m_hf   [NCFG];
  int         edge_n = 0;
  int         rel    = 0;

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_act[c] = 1'b0; m_k[c] = 0; m_cur[c] = 8'h00; m_hold[c] = 8'h00; m_hf[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic en, input logic [7:0] d);
    edge_n++;
    for (int c = 0; c < NCFG; c++) begin
      if (!m_act[c]) begin
        if (en) begin m_act[c] = 1'b1; m_k[c] = edge_n; m_cur[c] = d; end
      end else if (edge_n == m_k[c] + flen(c)) begin
        if (m_hf[c]) begin
          m_cur[c] = m_hold[c]; m_hf[c] = 1'b0; m_k[c] = edge_n;
        end else if (en) begin
          m_cur[c] = d; m_k[c] = edge_n;
        end else begin
          m_act[c] = 1'b0;
        end
      end else if (en && !m_hf[c]) begin
        m_hold[c] = d; m_hf[c] = 1'b1;
      end
    end
  endtask

  function automatic logic [2:0] m_exp(input int c);
    logic tx;
    tx = m_act[c] ? fbit(c, m_cur[c], (edge_n - m_k[c]) / DIV) : 1'b1;
    return {tx, m_act[c], ~m_hf[c]};
  endfunction

  task automatic step(input logic en, input logic [7:0] d);
    en_drv = en; data_drv = d;
    @(posedge sysclk);
    model_edge(en, d);
    rel++;
    #1;
    for (int c = 0; c < NCFG; c++) check($sformatf("model_cfg%0d", c), obs(c), m_exp(c));
  endtask

  task automatic run_to(input int at);
    while (rel <= at) step(1'b0, 8'h00);
  endtask

  // Independent 8N1 line receiver on the first instance; frames cut by reset are discarded.
  logic [7:0] rx_q [$];
  int rst_cnt = 0;
  always @(negedge reset) rst_cnt++;

  always begin : rx_blk
    int         r0;
    logic       ok;
    logic [7:0] b;
    @(negedge if0.uart_tx);
    r0 = rst_cnt; ok = 1'b1; b = 8'h00;
    repeat (DIV/2) @(posedge sysclk);
    #1 if (if0.uart_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge sysclk);
      #1 b[i] = if0.uart_tx;
    end
    repeat (DIV) @(posedge sysclk);
    #1 if (if0.uart_tx !== 1'b1) ok = 1'b0;
    if (ok && r0 == rst_cnt && reset) rx_q.push_back(b);
  end

  typedef struct {
    logic       start;
    int         at;
    logic       en;
    logic [7:0] d;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic s, input int at, input logic en, input logic [7:0] d,
                     input logic [2:0] exp);
    vec_t v;
    v.start = s; v.at = at; v.en = en; v.d = d; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected values on the 8N1 instance as {uart_tx, tx_busy, tx_status}.
    add(1,   0, 1, 8'hA5, 3'b011); add(0,   8, 0, 0, 3'b011); add(0,  15, 0, 0, 3'b011);
    add(0,  16, 0, 0, 3'b111); add(0,  40, 0, 0, 3'b011); add(0,  56, 0, 0, 3'b111);
    add(0,  72, 0, 0, 3'b011); add(0,  88, 0, 0, 3'b011); add(0, 104, 0, 0, 3'b111);
    add(0, 120, 0, 0, 3'b011); add(0, 136, 0, 0, 3'b111); add(0, 144, 0, 0, 3'b111);
    add(0, 159, 0, 0, 3'b111); add(0, 160, 0, 0, 3'b101);
    add(1,   0, 1, 8'h55, 3'b011); add(0,  39, 0, 0, 3'b011); add(0,  40, 1, 8'h0F, 3'b010);
    add(0,  41, 0, 0, 3'b010); add(0, 152, 0, 0, 3'b110); add(0, 159, 0, 0, 3'b110);
    add(0, 160, 0, 0, 3'b011); add(0, 184, 0, 0, 3'b111); add(0, 248, 0, 0, 3'b011);
    add(0, 319, 0, 0, 3'b111); add(0, 320, 0, 0, 3'b101);
    add(1,   0, 1, 8'h11, 3'b011); add(0,  20, 1, 8'h22, 3'b110); add(0,  30, 1, 8'h33, 3'b110);
    add(0, 160, 0, 0, 3'b011); add(0, 320, 0, 0, 3'b101); add(0, 360, 0, 0, 3'b101);

    model_reset();

    // Asynchronous reset asserted mid-cycle.
    #12 reset = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) check($sformatf("reset_async_cfg%0d", c), obs(c), 3'b101);
    repeat (3) @(posedge sysclk);
    @(negedge sysclk) reset = 1'b1;
    rel = 0;
    repeat (10) step(1'b0, 8'h00);
    check("reset_hold", obs0, 3'b101);

    // Directed vectors: single byte, back-to-back, overflow.
    rx_q.delete();
    foreach (vecs[i]) begin
      if (vecs[i].start) begin
        repeat (4) step(1'b0, 8'h00);
        rel = 0;
      end
      while (rel < vecs[i].at) step(1'b0, 8'h00);
      step(vecs[i].en, vecs[i].d);
      check($sformatf("vec%0d", i), obs0, vecs[i].exp);
    end
    check_int("rx_count", rx_q.size(), 5);
    if (rx_q.size() == 5) begin
      check_int("rx0", int'(rx_q[0]), 'hA5); check_int("rx1", int'(rx_q[1]), 'h55);
      check_int("rx2", int'(rx_q[2]), 'h0F); check_int("rx3", int'(rx_q[3]), 'h11);
      check_int("rx4", int'(rx_q[4]), 'h22);
    end

    // Parity values and stop-bit length with a queued second frame.
    repeat (4) step(1'b0, 8'h00);
    rel = 0;
    step(1'b1, 8'h07);
    step(1'b1, 8'h07);
    run_to(152);
    check_int("even_parity", int'(if1.uart_tx), 1);
    check_int("odd_parity", int'(if2.uart_tx), 0);
    run_to(175); check("8o1_last_stop", obs2, 3'b110);
    run_to(176); check("8o1_next_start", obs2, 3'b011);
    run_to(160); check("8e2_stop1", obs1, 3'b110);
    run_to(191); check("8e2_last_stop", obs1, 3'b110);
    run_to(192); check("8e2_next_start", obs1, 3'b011);
    run_to(383); check("8e2_end_busy", obs1, 3'b111);
    run_to(384); check("8e2_len_192", obs1, 3'b101);

    // Reset during data bit 3 of 0xC3, then a clean frame.
    repeat (4) step(1'b0, 8'h00);
    rel = 0;
    step(1'b1, 8'hC3);
    run_to(70);
    check("mid_frame_low", obs0, 3'b011);
    #3 reset = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) check($sformatf("reset_mid_cfg%0d", c), obs(c), 3'b101);
    model_reset();
    repeat (3) @(posedge sysclk);
    @(negedge sysclk) reset = 1'b1;
    repeat (200) step(1'b0, 8'h00);
    rx_q.delete();
    rel = 0;
    step(1'b1, 8'h3C);
    run_to(159); check("post_reset_busy", obs0, 3'b111);
    run_to(160); check("post_reset_len", obs0, 3'b101);
    run_to(200);
    check_int("post_reset_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check_int("post_reset_rx", int'(rx_q[0]), 'h3C);

    // Randomised traffic: sparse strobes, then dense bursts that overflow holding.
    repeat (4000) step(($urandom_range(0, 99) < 4), 8'($urandom));
    repeat (1500) step(($urandom_range(0, 9) < 5), 8'($urandom));
    repeat (400) step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
